// File: rtl/jts16b_pkg.sv
// Shared System 16B definitions: ADC sequencer states, channel codes and
// the signed-to-offset-binary conversion used by the analog inputs.
package jts16b_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        READY = 2'd2
    } adc_state_t;

    localparam logic [1:0] CH_SUM = 2'd0;
    localparam logic [1:0] CH_P1  = 2'd1;
    localparam logic [1:0] CH_P2  = 2'd2;
    localparam logic [1:0] CH_FF  = 2'd3;

    // Two's complement to offset binary: flip the sign bit.
    function automatic logic [7:0] to_offset(input logic signed [7:0] v);
        return {~v[7], v[6:0]};
    endfunction

endpackage

// File: rtl/jts16b_adc_seq_if.sv
// CPU-side access bus and analog inputs of the System 16B ADC sequencer.
interface jts16b_adc_seq_if;
    logic              cs;
    logic              we;
    logic [1:0]        ch;
    logic signed [7:0] ana1_y;
    logic signed [7:0] ana2_y;
    logic [7:0]        dout;
    logic              busy;

    modport master (
        output cs, we, ch, ana1_y, ana2_y,
        input  dout, busy
    );

    modport slave (
        input  cs, we, ch, ana1_y, ana2_y,
        output dout, busy
    );
endinterface

// File: rtl/jts16b_adc_src.sv
// Combinational ADC channel mux. JTS16B_ADC_SAT_EN selects a saturated
// player sum on channel 0; otherwise channel 0 uses the halved sum.
module jts16b_adc_src
    import jts16b_pkg::*;
(
    input  logic [1:0]        i_ch,
    input  logic signed [7:0] i_ana1_y,
    input  logic signed [7:0] i_ana2_y,
    output logic [7:0]        o_samp
);

    logic signed [8:0] w_sum;
    logic signed [7:0] w_red;

    assign w_sum = $signed({i_ana1_y[7], i_ana1_y}) + $signed({i_ana2_y[7], i_ana2_y});

`ifdef JTS16B_ADC_SAT_EN
    // Overflow shows up as disagreement between the two top sum bits.
    function automatic logic signed [7:0] sat8(input logic signed [8:0] v);
        if (v[8] != v[7])
            return v[8] ? 8'sh80 : 8'sh7f;
        return v[7:0];
    endfunction

    assign w_red = sat8(w_sum);
`else
    assign w_red = w_sum[8:1];
`endif

    always_comb begin
        o_samp = 8'hff;
        case (i_ch)
            CH_SUM:  o_samp = to_offset(w_red);
            CH_P1:   o_samp = to_offset(i_ana1_y);
            CH_P2:   o_samp = to_offset(i_ana2_y);
            CH_FF:   o_samp = 8'hff;
            default: o_samp = 8'hff;
        endcase
    end

endmodule

// File: rtl/jts16b_adc_seq.sv
// System 16B serial ADC sequencer: a CPU write starts a timed conversion,
// each later read returns one result bit MSB-first. Option: JTS16B_ADC_SAT_EN.
module jts16b_adc_seq
    import jts16b_pkg::*;
#(
    parameter int CONV_CYC = 64,
    parameter int CW       = 7
) (
    input  logic             clk,
    input  logic             rst,
    jts16b_adc_seq_if.slave  bus
);

    localparam logic [CW-1:0] LAST = CW'(CONV_CYC - 1);

    adc_state_t  r_state, w_state_nx;
    logic        r_cs_l;
    logic        r_rd_pend;
    logic [1:0]  r_ch;
    logic [CW-1:0] r_cnt;
    logic [7:0]  r_samp;
    logic [7:0]  r_shift;
    logic [3:0]  r_bitcnt;
    logic [7:0]  r_dout;

    logic        w_rise, w_fall, w_rd, w_wr;
    logic [1:0]  w_ch;
    logic [7:0]  w_src;

    assign w_rise = bus.cs & ~r_cs_l;
    assign w_fall = ~bus.cs & r_cs_l;
    assign w_rd   = w_rise & ~bus.we;
    assign w_wr   = w_rise & bus.we;
    assign w_ch   = w_wr ? bus.ch : r_ch;

    jts16b_adc_src u_src (
        .i_ch     (w_ch),
        .i_ana1_y (bus.ana1_y),
        .i_ana2_y (bus.ana2_y),
        .o_samp   (w_src)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE:  if (w_wr) w_state_nx = CONV;
            CONV:  if (!w_wr && r_cnt == LAST) w_state_nx = READY;
            READY: begin
                if (w_wr)
                    w_state_nx = CONV;
                else if (w_fall && r_rd_pend && r_bitcnt == 4'd1)
                    w_state_nx = IDLE;
            end
            default: w_state_nx = IDLE;
        endcase
    end

    // Bits advance on the falling edge of a read so long accesses yield one bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cs_l    <= 1'b0;
            r_rd_pend <= 1'b0;
            r_ch      <= 2'd0;
            r_cnt     <= '0;
            r_samp    <= 8'h00;
            r_shift   <= 8'h00;
            r_bitcnt  <= 4'd0;
            r_dout    <= 8'h00;
        end else begin
            r_cs_l <= bus.cs;
            if (w_wr) begin
                r_ch      <= bus.ch;
                r_samp    <= w_src;
                r_cnt     <= '0;
                r_rd_pend <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_rd) r_dout <= 8'h00;
                    end
                    CONV: begin
                        r_cnt <= r_cnt + CW'(1);
                        if (w_rd) r_dout <= 8'h01;
                        if (r_cnt == LAST) begin
                            r_shift  <= r_samp;
                            r_bitcnt <= 4'd8;
                        end
                    end
                    READY: begin
                        if (w_rd) begin
                            r_dout    <= {7'd0, r_shift[7]};
                            r_rd_pend <= 1'b1;
                        end else if (w_fall && r_rd_pend) begin
                            r_shift   <= {r_shift[6:0], 1'b0};
                            r_bitcnt  <= r_bitcnt - 4'd1;
                            r_rd_pend <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.dout = r_dout;
    assign bus.busy = (r_state == CONV);

endmodule

// File: tb/tb_jts16b_adc_seq.sv
// Scoreboard bench for jts16b_adc_seq: the driver predicts each read bit from
// a value-level model, a monitor compares dout at the end of every read.
module tb_jts16b_adc_seq;

    localparam int CONV_CYC = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    jts16b_adc_seq_if bus();

    jts16b_adc_seq #(.CONV_CYC(CONV_CYC), .CW(7)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];

    // Model: latest conversion result, bits already delivered, conversion pending.
    int m_res;
    int m_idx;
    bit m_conv;

    int busy_run = 0;
    int last_run = -1;
    bit cs_seen  = 1'b0;
    bit we_acc   = 1'b0;

    task automatic check(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int ref_val(input int c, input int a1, input int a2);
        int s;
        case (c)
            0: begin
                s = a1 + a2;
`ifdef JTS16B_ADC_SAT_EN
                if (s > 127)  s = 127;
                if (s < -128) s = -128;
`else
                if (s < 0) s = (s - 1) / 2;
                else       s = s / 2;
`endif
                return s + 128;
            end
            1: return a1 + 128;
            2: return a2 + 128;
            default: return 255;
        endcase
    endfunction

    function automatic void push_read();
        if (m_conv)
            exp_q.push_back(8'h01);
        else begin
            if (m_idx < 8) exp_q.push_back(8'((m_res >> (7 - m_idx)) & 1));
            else           exp_q.push_back(8'h00);
            m_idx++;
        end
    endfunction

    task automatic access(input bit w, input logic [1:0] c, input int len);
        @(negedge clk);
        bus.we = w;
        bus.ch = c;
        bus.cs = 1'b1;
        if (w) begin
            m_res  = ref_val(int'(c), int'(bus.ana1_y), int'(bus.ana2_y));
            m_idx  = 0;
            m_conv = 1'b1;
        end else
            push_read();
        repeat (len) @(negedge clk);
        bus.cs = 1'b0;
        bus.we = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_ready();
        repeat (CONV_CYC + 4) @(negedge clk);
        m_conv = 1'b0;
    endtask

    task automatic reads(input int n, input int len);
        for (int i = 0; i < n; i++) access(1'b0, 2'($urandom_range(0, 3)), len);
    endtask

    // Monitor: tracks busy run lengths and checks dout whenever a read access ends.
    initial begin
        logic [7:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (bus.busy) busy_run++;
            else if (busy_run != 0) begin
                last_run = busy_run;
                busy_run = 0;
            end
            if (!cs_seen && bus.cs) we_acc = bus.we;
            if (cs_seen && !bus.cs && !we_acc) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL dout_unexpected: got 0x%0h expected no read", bus.dout);
                end else begin
                    e = exp_q.pop_front();
                    check("dout", int'(bus.dout), int'(e));
                end
            end
            cs_seen = bus.cs;
        end
    end

    initial begin
        rst = 1'b1;
        bus.cs = 1'b0;
        bus.we = 1'b0;
        bus.ch = 2'd0;
        bus.ana1_y = 8'sh00;
        bus.ana2_y = 8'sh00;
        m_res = 0;
        m_idx = 8;
        m_conv = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_dout", int'(bus.dout), 0);
        check("reset_busy", int'(bus.busy), 0);
        rst = 1'b0;
        @(negedge clk);
        reads(1, 2);

        // Channel 1, busy width and full shift-out plus one extra read.
        bus.ana1_y = 8'sh25;
        last_run = -1;
        access(1'b1, 2'd1, 2);
        wait_ready();
        check("busy_width", last_run, CONV_CYC);
        reads(9, 2);

        // Channel 2 with a read during conversion.
        bus.ana2_y = 8'sh9c;
        access(1'b1, 2'd2, 1);
        repeat (6) @(negedge clk);
        access(1'b0, 2'd0, 2);
        check("busy_mid_conv", int'(bus.busy), 1);
        wait_ready();
        reads(8, 3);

        // Channel 0 sum of two equal large values.
        bus.ana1_y = 8'sh70;
        bus.ana2_y = 8'sh70;
        access(1'b1, 2'd0, 2);
        wait_ready();
        reads(8, 1);

        // Constant channel, partial read, then a write restarts the sequence.
        access(1'b1, 2'd3, 1);
        wait_ready();
        reads(3, 2);
        bus.ana1_y = 8'sh80;
        access(1'b1, 2'd1, 1);
        check("restart_busy", int'(bus.busy), 1);
        wait_ready();
        reads(9, 1);

        // Sample is captured at the write edge, not at conversion end.
        @(negedge clk);
        bus.ana1_y = 8'sh10;
        bus.we = 1'b1;
        bus.ch = 2'd1;
        bus.cs = 1'b1;
        m_res = ref_val(1, 16, int'(bus.ana2_y));
        m_idx = 0;
        m_conv = 1'b1;
        repeat (2) @(negedge clk);
        bus.ana1_y = 8'sh7f;
        bus.cs = 1'b0;
        bus.we = 1'b0;
        @(negedge clk);
        wait_ready();
        reads(8, 2);

        // Reset in the middle of a conversion, and a long read access.
        access(1'b1, 2'd1, 1);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_busy", int'(bus.busy), 0);
        check("rst_mid_dout", int'(bus.dout), 0);
        @(negedge clk);
        rst = 1'b0;
        m_conv = 1'b0;
        m_idx = 8;
        reads(1, 2);
        access(1'b1, 2'd3, 1);
        wait_ready();
        reads(2, 20);

        // Randomized traffic.
        for (int it = 0; it < 40; it++) begin
            bus.ana1_y = 8'($urandom);
            bus.ana2_y = 8'($urandom);
            access(1'b1, 2'($urandom_range(0, 3)), $urandom_range(1, 6));
            bus.ana1_y = 8'($urandom);
            bus.ana2_y = 8'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(0, 15)) @(negedge clk);
                access(1'b0, 2'd0, $urandom_range(1, 3));
            end
            wait_ready();
            reads($urandom_range(0, 10), $urandom_range(1, 8));
        end

        repeat (5) @(negedge clk);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
